// File: rtl/mem_stage_access.sv
// ============================================================================
// mem_stage_access : M-stage load/store unit with a 3-state bus FSM.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  SizeM,
    input  logic        SignedM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        DoneM,
    output logic [31:0] ReadDataM,
    output logic        AlignErrM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_rdata;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_sign;
    logic [1:0]         r_lane;

    logic               w_req;
    logic               w_misalign;
    logic               w_start;
    logic               w_timeout;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [7:0]         w_rbyte;
    logic [15:0]        w_rhalf;
    logic [31:0]        w_rfmt;

    assign w_req = MemReadM | MemWriteM;

    always_comb begin
        w_misalign = 1'b0;
        case (SizeM)
            c_SZ_BYTE: w_misalign = 1'b0;
            c_SZ_HALF: w_misalign = AddrM[0];
            c_SZ_WORD: w_misalign = (AddrM[1:0] != 2'b00);
            default:   w_misalign = 1'b1;
        endcase
    end

    assign w_start   = (r_state == c_S_IDLE) & w_req & ~w_misalign;
    assign w_timeout = (r_state == c_S_ACCESS) & ~mem_ack & (r_cnt == c_CNT_LAST);

    // Lane enables and replicated store data, captured when the access starts
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
        case (SizeM)
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << AddrM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            c_SZ_HALF: begin
                w_be    = 4'b0011 << {AddrM[1], 1'b0};
                w_wdata = {2{WriteDataM[15:0]}};
            end
            c_SZ_WORD: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = WriteDataM;
            end
        endcase
    end

    always_comb begin
        w_rbyte = mem_rdata[7:0];
        case (r_lane)
            2'd0:    w_rbyte = mem_rdata[7:0];
            2'd1:    w_rbyte = mem_rdata[15:8];
            2'd2:    w_rbyte = mem_rdata[23:16];
            default: w_rbyte = mem_rdata[31:24];
        endcase
    end

    assign w_rhalf = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_rfmt = mem_rdata;
        case (r_size)
            c_SZ_BYTE: w_rfmt = {{24{r_sign & w_rbyte[7]}}, w_rbyte};
            c_SZ_HALF: w_rfmt = {{16{r_sign & w_rhalf[15]}}, w_rhalf};
            default:   w_rfmt = mem_rdata;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_rdata <= 32'h0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_lane  <= 2'b00;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= {AddrM[31:2], 2'b00};
                        r_we    <= MemWriteM;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_size  <= SizeM;
                        r_sign  <= SignedM;
                        r_lane  <= AddrM[1:0];
                        r_cnt   <= '0;
                        r_state <= c_S_ACCESS;
                    end
                end
                c_S_ACCESS: begin
                    // An ack in the timeout cycle still completes normally
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_rdata <= w_rfmt;
                        end
                        r_state <= c_S_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        if (!r_we) begin
                            r_rdata <= 32'h0;
                        end
                        r_state <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign StallM    = (r_state == c_S_ACCESS) | w_start;
    assign AlignErrM = (r_state == c_S_IDLE) & w_req & w_misalign;
    assign DoneM     = (r_state == c_S_DONE);
    assign BusErrM   = w_timeout & ~RST;
    assign mem_req   = (r_state == c_S_ACCESS);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign ReadDataM = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_access.sv
// ============================================================================
// tb_mem_stage_access : directed self-checking bench for mem_stage_access.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_access;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM, MemWriteM, SignedM, mem_ack;
    logic [1:0]  SizeM;
    logic [31:0] AddrM, WriteDataM, mem_rdata;
    logic        StallM, DoneM, AlignErrM, BusErrM, mem_req, mem_we;
    logic [31:0] ReadDataM, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    mem_stage_access #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .SizeM(SizeM), .SignedM(SignedM),
        .AddrM(AddrM), .WriteDataM(WriteDataM),
        .StallM(StallM), .DoneM(DoneM), .ReadDataM(ReadDataM),
        .AlignErrM(AlignErrM), .BusErrM(BusErrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        MemReadM = 1'b0; MemWriteM = 1'b0; SizeM = 2'b00; SignedM = 1'b0;
        AddrM = 32'h0; WriteDataM = 32'h0;
    endtask

    // One complete transaction from IDLE; ack_at = ACCESS cycle carrying mem_ack (0 = never)
    task automatic xfer(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ack_at,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                        input int exp_stalls, input int exp_berr_cyc);
        int   stalls = 0;
        int   berr_cyc = 0;
        logic stable = 1'b1;
        MemReadM = rd; MemWriteM = wr; SizeM = sz; SignedM = sgn;
        AddrM = addr; WriteDataM = wdata;
        #1;
        check_eq({tag, ".align"}, {31'b0, AlignErrM}, 32'd0);
        if (StallM) stalls++;
        tick;
        check_eq({tag, ".addr"}, mem_addr, exp_addr);
        check_eq({tag, ".be"}, {28'b0, mem_be}, {28'b0, exp_be});
        check_eq({tag, ".we"}, {31'b0, mem_we}, {31'b0, wr});
        if (wr) check_eq({tag, ".wdata"}, mem_wdata, exp_wdata);
        for (int c = 1; c <= 40; c++) begin
            if (!mem_req) break;
            if (StallM) stalls++;
            if (mem_addr !== exp_addr || mem_be !== exp_be || mem_we !== wr ||
                (wr && mem_wdata !== exp_wdata)) stable = 1'b0;
            mem_rdata = rdata;
            mem_ack   = (c == ack_at);
            #1;
            if (BusErrM === 1'b1 && berr_cyc == 0) berr_cyc = c;
            tick;
            mem_ack = 1'b0;
        end
        check_eq({tag, ".stable"}, {31'b0, stable}, 32'd1);
        check_eq({tag, ".berr_cyc"}, berr_cyc, exp_berr_cyc);
        check_eq({tag, ".done"}, {30'b0, DoneM, StallM}, 32'd2);
        check_eq({tag, ".stalls"}, stalls, exp_stalls);
        check_eq({tag, ".rdata"}, ReadDataM, exp_rd);
        clear_inputs();
        tick;
        check_eq({tag, ".done_clr"}, {31'b0, DoneM}, 32'd0);
        check_eq({tag, ".rd_hold"}, ReadDataM, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        RST = 1'b1;
        tick; tick;
        check_eq("rst.outs", {26'b0, mem_req, mem_we, DoneM, BusErrM, StallM, AlignErrM}, 32'd0);
        check_eq("rst.rdata", ReadDataM, 32'h0);
        check_eq("rst.addr", mem_addr, 32'h0);
        check_eq("rst.wdata_be", {mem_wdata[27:0], mem_be}, 32'h0);

        // First cycle out of reset follows the IDLE rules
        RST = 1'b0;
        MemReadM = 1'b1; SizeM = 2'b10; AddrM = 32'h0000_0002;
        #1;
        check_eq("post_rst.align_stall", {30'b0, AlignErrM, StallM}, 32'd2);
        clear_inputs();
        tick;

        // Ack while idle must be ignored
        mem_ack = 1'b1;
        tick;
        check_eq("idle_ack", {30'b0, mem_req, DoneM}, 32'd0);
        mem_ack = 1'b0;
        tick;

        xfer("lb_s", 1, 0, 2'b00, 1, 32'h1003, 32'h0, 32'h8011_2233, 1,
             32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 2, 0);
        xfer("sh", 0, 1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 32'h0, 4,
             32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80, 5, 0);
        xfer("lhu", 1, 0, 2'b01, 0, 32'h1002, 32'h0, 32'h8011_2233, 1,
             32'h1000, 4'b1100, 32'h0, 32'h0000_8011, 2, 0);
        xfer("lh_s", 1, 0, 2'b01, 1, 32'h1002, 32'h0, 32'h8011_2233, 2,
             32'h1000, 4'b1100, 32'h0, 32'hFFFF_8011, 3, 0);
        xfer("lbu", 1, 0, 2'b00, 0, 32'h1001, 32'h0, 32'h8011_2233, 1,
             32'h1000, 4'b0010, 32'h0, 32'h0000_0022, 2, 0);
        xfer("sb", 0, 1, 2'b00, 0, 32'h5002, 32'h0000_00A5, 32'h0, 1,
             32'h5000, 4'b0100, 32'hA5A5_A5A5, 32'h0000_0022, 2, 0);
        xfer("rw_sw", 1, 1, 2'b10, 0, 32'h6004, 32'hDEAD_BEEF, 32'h1111_1111, 1,
             32'h6004, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0022, 2, 0);
        xfer("tmo", 1, 0, 2'b10, 0, 32'h0100, 32'h0, 32'h5555_5555, 0,
             32'h0100, 4'b1111, 32'h0, 32'h0, 17, 16);
        xfer("ack_last", 1, 0, 2'b10, 0, 32'h0104, 32'h0, 32'hCAFE_F00D, 16,
             32'h0104, 4'b1111, 32'h0, 32'hCAFE_F00D, 17, 0);

        // Misaligned word: no bus activity, no stall, held for several cycles
        MemReadM = 1'b1; SizeM = 2'b10; AddrM = 32'h3001;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("mis_w", {28'b0, AlignErrM, StallM, mem_req, DoneM}, 32'h8);
            tick;
        end
        SizeM = 2'b11; AddrM = 32'h3000;
        #1; check_eq("mis_sz11", {31'b0, AlignErrM}, 32'd1);
        SizeM = 2'b01; AddrM = 32'h3003;
        #1; check_eq("mis_half", {31'b0, AlignErrM}, 32'd1);
        SizeM = 2'b01; AddrM = 32'h3002;
        #1; check_eq("ok_half", {30'b0, AlignErrM, StallM}, 32'd1);
        clear_inputs();
        tick;
        check_eq("mis_noreq", {31'b0, mem_req}, 32'd0);

        // Reset during the second ACCESS cycle
        MemReadM = 1'b1; SizeM = 2'b10; AddrM = 32'h7000;
        tick;
        tick;
        check_eq("rst_mid.req", {31'b0, mem_req}, 32'd1);
        RST = 1'b1;
        clear_inputs();
        tick;
        check_eq("rst_mid.outs", {28'b0, mem_req, DoneM, BusErrM, StallM}, 32'd0);
        check_eq("rst_mid.rdata", ReadDataM, 32'h0);
        RST = 1'b0;
        tick;
        check_eq("rst_mid.nodone", {30'b0, mem_req, DoneM}, 32'd0);

        xfer("lw_after_rst", 1, 0, 2'b10, 0, 32'h4000, 32'h0, 32'h1234_5678, 1,
             32'h4000, 4'b1111, 32'h0, 32'h1234_5678, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage_access.md
MEM_STAGE_ACCESS -- requirements
Module: mem_stage_access

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 16, the number of ACCESS cycles without mem_ack before a bus error is raised.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- CLK  in  1  pipeline clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- MemReadM  in  1  load in M stage.
- MemWriteM  in  1  store in M stage.
- SizeM  in  2  00 byte, 01 half, 10 word, 11 illegal.
- SignedM  in  1  sign-extend load data.
- AddrM  in  32  byte address (ALUOutM).
- WriteDataM  in  32  store data, right-justified.
- StallM  out  1  freeze F/D/E/M pipeline registers.
- DoneM  out  1  1-cycle pulse: access completed this cycle.
- ReadDataM  out  32  formatted load data to the M/W register.
- AlignErrM  out  1  misaligned or illegal access.
- BusErrM  out  1  access timed out.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address, bits [1:0] = 0.
- mem_be  out  4  byte enables, bit n = byte lane n.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  bus read data.
- mem_ack  in  1  bus completion.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-004 Request = MemReadM | MemWriteM; when both are set, the block SHALL perform a write.
REQ-005 Misaligned SHALL be true for: SizeM=01 with AddrM[0]=1; SizeM=10 with AddrM[1:0]≠0; SizeM=11.
REQ-006 In IDLE, on a misaligned request: AlignErrM=1 that cycle (combinational), no bus access, StallM=0, DoneM=0, state stays IDLE.
REQ-007 In IDLE, on an aligned request:
- StallM=1 (combinational).
- Register mem_addr={AddrM[31:2],2'b00}, mem_we, mem_be, mem_wdata, size, sign and lane.
- Clear the timeout counter; next state ACCESS.
REQ-008 Byte enables:
- Byte: mem_be = 4'b0001<<AddrM[1:0].
- Half: mem_be = 4'b0011<<{AddrM[1],1'b0}.
- Word: mem_be = 4'b1111.
REQ-009 Store data SHALL be replicated: byte in all 4 lanes; half in both halves; word unchanged.
REQ-010 In ACCESS:
- mem_req=1 and StallM=1.
- mem_addr, mem_we, mem_be and mem_wdata SHALL hold stable until ack or timeout.
- The counter SHALL increment each cycle without ack.
REQ-011 In ACCESS with mem_ack=1, the block SHALL go to DONE. On a read it SHALL load ReadDataM with the selected lane, zero- or sign-extended to 32 bits; word reads pass unchanged.
REQ-012 In ACCESS when the counter reaches TIMEOUT_CYCLES-1 without ack:
- BusErrM=1 for one cycle.
- On a read, ReadDataM <= 0.
- Next state DONE.
REQ-013 mem_ack arriving in the same cycle as the timeout SHALL take priority: no BusErrM.
REQ-014 In DONE: StallM=0 and DoneM=1 for exactly one cycle, so the pipeline advances on that edge; next state IDLE, and the M-stage inputs are not re-sampled until the cycle after.
REQ-015 mem_ack in IDLE or DONE SHALL be ignored.
REQ-016 ReadDataM SHALL hold its value between loads and SHALL be unchanged by stores.
REQ-017 Minimum latency SHALL be 3 cycles from request to advance: IDLE, ACCESS with ack, DONE.

Reset
REQ-018 With RST=1 at a posedge, the block SHALL force:
- state IDLE and counter 0;
- ReadDataM, mem_addr, mem_wdata = 0;
- mem_be = 0 and mem_we = 0;
- DoneM, BusErrM = 0.
REQ-019 Reset in ACCESS SHALL drop mem_req on the next cycle and generate no DoneM or BusErrM.
REQ-020 Combinational outputs (StallM, AlignErrM) SHALL follow the IDLE rules in the first cycle after reset.

Verification
REQ-021 Load byte: AddrM=0x1003, SizeM=00, SignedM=1, mem_rdata=0x80112233, ack on 1st ACCESS cycle -> mem_be=1000, mem_addr=0x1000, ReadDataM=0xFFFFFF80, DoneM in cycle 2.
REQ-022 Store half: AddrM=0x2002, SizeM=01, WriteDataM=0x0000BEEF, ack after 3 wait cycles -> mem_be=1100, mem_wdata=0xBEEFBEEF, StallM=1 for 5 cycles, then DoneM.
REQ-023 Misaligned word: AddrM=0x3001, SizeM=10 -> AlignErrM=1, mem_req never asserted, StallM=0.
REQ-024 Timeout: load with mem_ack tied 0, TIMEOUT_CYCLES=16 -> BusErrM pulse on the 16th ACCESS cycle, ReadDataM=0, DoneM on the next cycle.
REQ-025 Reset mid-access: RST asserted on the 2nd ACCESS cycle -> mem_req=0 the following cycle, state IDLE, no DoneM; a later load of 0x12345678 (word) -> ReadDataM=0x12345678.
